change_hopper: RTL and testbench
================================

CHANGE_HOPPER -- requirements
Module: change_hopper

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- TIMEOUT, 16, max cycles from coin request to COIN_SENSE before jam.
- GAP_CYCLES, 2, motor-off cycles between consecutive coins.
- INIT_COUNT, 50, per-denomination inventory value loaded at reset/RELOAD.
REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- CLOCK  in  1  single clock; all logic on its negative edge.
- nRESET  in  1  asynchronous, active-low reset.
- C1  in  1  one-cycle request: dispense one 1-unit coin.
- C5  in  1  one-cycle request: dispense one 5-unit coin.
- C10  in  1  one-cycle request: dispense one 10-unit coin.
- COIN_SENSE  in  1  exit-chute sensor; high means a coin has left.
- RELOAD  in  1  synchronous active-high; refill inventory.
- CLR_JAM  in  1  synchronous active-high; clear jam.
- MOTOR_1, MOTOR_5, MOTOR_10  out  1 each  registered hopper motor drives.
- BUSY  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- JAM  out  1  high while in the JAM state.
- DROP  out  1  sticky; a request was lost.
- EMPTY_1, EMPTY_5, EMPTY_10  out  1 each  inventory count is zero.

Function
REQ-003 SHALL queue requests in an 8-entry FIFO of 2-bit denomination codes, with one push per cycle.
REQ-004 If two or more of C1/C5/C10 are high in the same cycle, the block SHALL push only the highest (C10>C5>C1) and SHALL set DROP.
REQ-005 A push to a full FIFO SHALL be discarded and SHALL set DROP, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-006 The FSM SHALL have states IDLE, WAIT_EXIT, GAP, and JAM.
REQ-007 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry and enter WAIT_EXIT.
- The matching MOTOR output SHALL go high at that same edge.
- A request into an empty idle block is therefore driving its motor one edge after it is sampled.
REQ-008 In WAIT_EXIT, COIN_SENSE high SHALL:
- deassert the motor,
- decrement that denomination's inventory,
- enter GAP.
REQ-009 In WAIT_EXIT, TIMEOUT cycles without COIN_SENSE SHALL deassert the motor and enter JAM. The timeout count starts at 1 on the pop edge.
REQ-010 GAP SHALL last exactly GAP_CYCLES cycles with all motors low, then return to IDLE.
REQ-011 JAM SHALL hold JAM=1 and all motors low, and SHALL return to IDLE on CLR_JAM. FIFO contents SHALL be retained, and pushes SHALL continue to be accepted.
REQ-012 COIN_SENSE SHALL be ignored outside WAIT_EXIT.
REQ-013 At most one MOTOR output SHALL be high in any cycle.
REQ-014 RELOAD SHALL set all counts to INIT_COUNT when sampled in IDLE, and SHALL be ignored in other states.
REQ-015 Inventory counts SHALL be 8 bits wide and SHALL saturate at 0, never wrapping.

Reset
REQ-016 On nRESET low, the block SHALL immediately:
- enter IDLE,
- empty the FIFO,
- clear the timeout and gap counters,
- set all motors, JAM, and DROP to 0,
- set inventory counts to INIT_COUNT.
REQ-017 The same reset effects SHALL apply mid-dispense: the motor drops asynchronously, and the coin in flight is neither counted nor retried.
REQ-018 The only way to clear DROP SHALL be nRESET.

Configuration
REQ-019 The macro HOPPER_INVENTORY_EN SHALL compile the inventory feature in or out.
- Defined: inventory counters, EMPTY outputs, and RELOAD are active. A popped entry whose count is 0 SHALL be discarded without driving a motor, SHALL set DROP, and the FSM SHALL stay in IDLE.
- Undefined: no counters are built, EMPTY outputs are tied to 0, RELOAD is ignored, and every popped entry is dispensed.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single request: C5 pulse in IDLE, COIN_SENSE 3 cycles after MOTOR_5 rises -> MOTOR_5 high for 3 cycles, count5 = 49, low for 2 GAP cycles, BUSY low afterwards.
- Burst and full FIFO: C10 for 9 consecutive cycles with COIN_SENSE held off -> first entry popped, the following 8 queued, none dropped; 10th pulse -> DROP = 1.
- Simultaneous requests and jam: C1 and C10 together -> only MOTOR_10 fires and DROP = 1; no COIN_SENSE for 16 cycles -> JAM = 1, motor low; CLR_JAM -> next queued entry dispensed.
- Empty denomination (HOPPER_INVENTORY_EN defined): INIT_COUNT = 1, two C1 requests -> one coin, EMPTY_1 = 1, second request discarded with DROP = 1; RELOAD in IDLE -> EMPTY_1 = 0.
- Reset mid-dispense: nRESET low while MOTOR_10 high -> MOTOR_10 low without waiting for a clock edge, FIFO empty, counts = INIT_COUNT, DROP = 0.
- Macro undefined: INIT_COUNT = 0, C1 -> MOTOR_1 still fires, EMPTY_1 stays 0.

Source files
------------

// File: rtl/change_hopper.sv
// change_hopper: three-denomination coin hopper controller.
// Requests are queued in an 8-deep FIFO and dispensed one coin at a time.
// Each coin drives its motor until the exit sensor fires, then a motor-off
// gap follows. A missing sensor pulse jams the block until CLR_JAM.
// All state changes on the falling edge of CLOCK. nRESET is asynchronous.
// Optional macro HOPPER_INVENTORY_EN adds per-denomination coin counters,
// the EMPTY_* flags and RELOAD.
module change_hopper #(
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 2,
    parameter int INIT_COUNT = 50
) (
    input  logic CLOCK,
    input  logic nRESET,
    input  logic C1,
    input  logic C5,
    input  logic C10,
    input  logic COIN_SENSE,
    input  logic RELOAD,
    input  logic CLR_JAM,
    output logic MOTOR_1,
    output logic MOTOR_5,
    output logic MOTOR_10,
    output logic BUSY,
    output logic JAM,
    output logic DROP,
    output logic EMPTY_1,
    output logic EMPTY_5,
    output logic EMPTY_10
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EXIT, S_GAP, S_JAM} state_t;

    // Denomination codes: 0 = 1-unit, 1 = 5-unit, 2 = 10-unit.
    // The code doubles as the motor bit index and the counter index.
    state_t        state_q, state_d;
    logic [1:0]    mem_q [8];
    logic [1:0]    mem_d [8];
    logic [2:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    wr_ptr_q, wr_ptr_d;
    logic [3:0]    fcnt_q, fcnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    motor_q, motor_d;
    logic          drop_q, drop_d;

    logic          pop, push_ok;
    logic [1:0]    head;
    logic [1:0]    req_code;
    logic          req_any, req_multi;

`ifdef HOPPER_INVENTORY_EN
    logic [1:0]    den_q, den_d;
    logic [7:0]    inv_q [3];
    logic [7:0]    inv_d [3];
`endif

    // Request priority: highest denomination wins, any collision is a loss.
    assign req_any   = C1 | C5 | C10;
    assign req_multi = (C1 & C5) | (C1 & C10) | (C5 & C10);
    assign req_code  = C10 ? 2'd2 : (C5 ? 2'd1 : 2'd0);

    // Next-state logic for dispense FSM, FIFO and inventory.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        motor_d  = motor_q;
        drop_d   = drop_q;
`ifdef HOPPER_INVENTORY_EN
        den_d    = den_q;
        inv_d    = inv_q;
`endif
        pop      = 1'b0;
        push_ok  = 1'b0;
        head     = mem_q[rd_ptr_q];

        case (state_q)
            S_IDLE: begin
                if (fcnt_q != 4'd0) begin
                    pop = 1'b1;
`ifdef HOPPER_INVENTORY_EN
                    // Out of stock: swallow the entry, flag it, stay idle.
                    if (inv_q[head] == 8'd0) begin
                        drop_d = 1'b1;
                    end else begin
                        den_d   = head;
                        state_d = S_WAIT_EXIT;
                        motor_d = 3'b001 << head;
                        tmr_d   = TW'(1);
                    end
`else
                    state_d = S_WAIT_EXIT;
                    motor_d = 3'b001 << head;
                    tmr_d   = TW'(1);
`endif
                end
`ifdef HOPPER_INVENTORY_EN
                if (RELOAD) begin
                    for (int i = 0; i < 3; i++) inv_d[i] = 8'(INIT_COUNT);
                end
`endif
            end
            S_WAIT_EXIT: begin
                if (COIN_SENSE) begin
                    motor_d = 3'b000;
                    state_d = S_GAP;
                    gap_d   = GW'(1);
`ifdef HOPPER_INVENTORY_EN
                    if (inv_q[den_q] != 8'd0) inv_d[den_q] = inv_q[den_q] - 8'd1;
`endif
                end else if (tmr_q == TW'(TIMEOUT)) begin
                    motor_d = 3'b000;
                    state_d = S_JAM;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_JAM: begin
                if (CLR_JAM) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A full FIFO still takes a push when the head leaves this cycle.
        if (req_multi) drop_d = 1'b1;
        push_ok = req_any && ((fcnt_q != 4'd8) || pop);
        if (req_any && !push_ok) drop_d = 1'b1;
        if (push_ok) begin
            mem_d[wr_ptr_q] = req_code;
            wr_ptr_d        = wr_ptr_q + 3'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 3'd1;
        fcnt_d = fcnt_q + {3'b000, push_ok} - {3'b000, pop};
    end

    // State registers; reset drops the motors immediately and forgets the coin in flight.
    always_ff @(negedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < 8; i++) mem_q[i] <= 2'd0;
            rd_ptr_q <= 3'd0;
            wr_ptr_q <= 3'd0;
            fcnt_q   <= 4'd0;
            tmr_q    <= '0;
            gap_q    <= '0;
            motor_q  <= 3'b000;
            drop_q   <= 1'b0;
`ifdef HOPPER_INVENTORY_EN
            den_q    <= 2'd0;
            for (int i = 0; i < 3; i++) inv_q[i] <= 8'(INIT_COUNT);
`endif
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fcnt_q   <= fcnt_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            motor_q  <= motor_d;
            drop_q   <= drop_d;
`ifdef HOPPER_INVENTORY_EN
            den_q    <= den_d;
            inv_q    <= inv_d;
`endif
        end
    end

    assign MOTOR_1  = motor_q[0];
    assign MOTOR_5  = motor_q[1];
    assign MOTOR_10 = motor_q[2];
    assign BUSY     = (state_q != S_IDLE) || (fcnt_q != 4'd0);
    assign JAM      = (state_q == S_JAM);
    assign DROP     = drop_q;

`ifdef HOPPER_INVENTORY_EN
    assign EMPTY_1  = (inv_q[0] == 8'd0);
    assign EMPTY_5  = (inv_q[1] == 8'd0);
    assign EMPTY_10 = (inv_q[2] == 8'd0);
`else
    logic unused_reload;
    assign unused_reload = RELOAD;
    assign EMPTY_1  = 1'b0;
    assign EMPTY_5  = 1'b0;
    assign EMPTY_10 = 1'b0;
`endif

endmodule

// File: tb/tb_change_hopper.sv
// tb_change_hopper: directed scenarios plus randomized traffic against a
// queue-based reference model of the hopper. Instance u_a uses the default
// stock of 50 coins; u_b uses a tiny stock to reach the empty corner cases.
module tb_change_hopper;
`ifdef HOPPER_INVENTORY_EN
    localparam bit INV    = 1'b1;
    localparam int B_INIT = 1;
`else
    localparam bit INV    = 1'b0;
    localparam int B_INIT = 0;
`endif
    localparam int TMO  = 16;
    localparam int GAPC = 2;
    localparam int INIT = 50;
    localparam int M_IDLE = 0, M_WAIT = 1, M_GAP = 2, M_JAM = 3;

    logic clk   = 1'b1;
    logic rst_n = 1'b0;
    logic c1 = 1'b0, c5 = 1'b0, c10 = 1'b0, sense = 1'b0, reload = 1'b0, clr = 1'b0;
    logic b_c1 = 1'b0, b_sense = 1'b0, b_reload = 1'b0;
    logic m1, m5, m10, busy, jam, drop, e1, e5, e10;
    logic bm1, bm5, bm10, bbusy, bjam, bdrop, be1, be5, be10;
    logic [8:0] a_outs, b_outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    change_hopper #(.TIMEOUT(TMO), .GAP_CYCLES(GAPC), .INIT_COUNT(INIT)) u_a (
        .CLOCK(clk), .nRESET(rst_n), .C1(c1), .C5(c5), .C10(c10),
        .COIN_SENSE(sense), .RELOAD(reload), .CLR_JAM(clr),
        .MOTOR_1(m1), .MOTOR_5(m5), .MOTOR_10(m10), .BUSY(busy), .JAM(jam),
        .DROP(drop), .EMPTY_1(e1), .EMPTY_5(e5), .EMPTY_10(e10)
    );

    change_hopper #(.TIMEOUT(TMO), .GAP_CYCLES(GAPC), .INIT_COUNT(B_INIT)) u_b (
        .CLOCK(clk), .nRESET(rst_n), .C1(b_c1), .C5(1'b0), .C10(1'b0),
        .COIN_SENSE(b_sense), .RELOAD(b_reload), .CLR_JAM(1'b0),
        .MOTOR_1(bm1), .MOTOR_5(bm5), .MOTOR_10(bm10), .BUSY(bbusy), .JAM(bjam),
        .DROP(bdrop), .EMPTY_1(be1), .EMPTY_5(be5), .EMPTY_10(be10)
    );

    assign a_outs = {m1, m5, m10, busy, jam, drop, e1, e5, e10};
    assign b_outs = {bm1, bm5, bm10, bbusy, bjam, bdrop, be1, be5, be10};

    // Reference model: pending coins as a queue, current activity as a mode.
    int mq[$];
    int m_mode, m_den, m_t, m_g;
    int m_cnt[3];
    bit m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mode = M_IDLE; m_den = 0; m_t = 0; m_g = 0; m_drop = 1'b0;
        for (int k = 0; k < 3; k++) m_cnt[k] = INIT;
    endtask

    task automatic model_step(input bit i1, i5, i10, is, ir, ic);
        int n, d;
        case (m_mode)
            M_IDLE: begin
                if (mq.size() > 0) begin
                    d = mq.pop_front();
                    if (INV && m_cnt[d] == 0) m_drop = 1'b1;
                    else begin m_mode = M_WAIT; m_den = d; m_t = 1; end
                end
                if (INV && ir) for (int k = 0; k < 3; k++) m_cnt[k] = INIT;
            end
            M_WAIT: begin
                if (is) begin
                    if (INV && m_cnt[m_den] > 0) m_cnt[m_den]--;
                    m_mode = M_GAP; m_g = 1;
                end else if (m_t == TMO) m_mode = M_JAM;
                else m_t++;
            end
            M_GAP: if (m_g == GAPC) m_mode = M_IDLE; else m_g++;
            default: if (ic) m_mode = M_IDLE;
        endcase
        n = int'(i1) + int'(i5) + int'(i10);
        if (n > 1) m_drop = 1'b1;
        if (n > 0) begin
            if (mq.size() < 8) mq.push_back(i10 ? 2 : (i5 ? 1 : 0));
            else m_drop = 1'b1;
        end
    endtask

    function automatic logic [8:0] model_outs();
        logic [8:0] o;
        o[8] = (m_mode == M_WAIT) && (m_den == 0);
        o[7] = (m_mode == M_WAIT) && (m_den == 1);
        o[6] = (m_mode == M_WAIT) && (m_den == 2);
        o[5] = (m_mode != M_IDLE) || (mq.size() > 0);
        o[4] = (m_mode == M_JAM);
        o[3] = m_drop;
        o[2] = INV && (m_cnt[0] == 0);
        o[1] = INV && (m_cnt[1] == 0);
        o[0] = INV && (m_cnt[2] == 0);
        return o;
    endfunction

    // One clock: drive at rising edge, DUT samples at falling edge, compare at next rising edge.
    task automatic cyc(input bit i1, i5, i10, is, ir, ic);
        c1 = i1; c5 = i5; c10 = i10; sense = is; reload = ir; clr = ic;
        @(negedge clk);
        model_step(i1, i5, i10, is, ir, ic);
        @(posedge clk);
        chk("outs", 32'(a_outs), 32'(model_outs()));
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_m10"}, 32'(m10), 32'd0);
        chk({tag, "_outs"}, 32'(a_outs), 32'd0);
        model_reset();
        @(posedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        chk("rst_a", 32'(a_outs), 32'd0);
        chk("rst_b", 32'(b_outs), 32'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Single 5-unit coin, sensor three cycles after motor start.
        cyc(0, 1, 0, 0, 0, 0);  chk("s1_push_no_motor", 32'(m5), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);  chk("s1_m5_on", 32'(m5), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);  chk("s1_m5_hold", 32'(m5), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);  chk("s1_m5_off", 32'(m5), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);  chk("s1_gap_busy", 32'(busy), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);  chk("s1_idle", 32'(busy), 32'd0);

        // Burst of 10-unit requests: 1 in flight + 8 queued, 10th is lost.
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("s2_no_drop", 32'(drop), 32'd0);
        chk("s2_m10", 32'(m10), 32'd1);
        cyc(0, 0, 1, 0, 0, 0);  chk("s2_drop", 32'(drop), 32'd1);

        // Reset while the motor runs: outputs fall before any clock edge.
        async_reset("rst_mid");

        // Collision, then jam after TIMEOUT cycles, then recovery.
        cyc(1, 0, 1, 0, 0, 0);  chk("s3_drop", 32'(drop), 32'd1);
        cyc(0, 1, 0, 0, 0, 0);  chk("s3_m10", 32'(m10), 32'd1);
        chk("s3_m1", 32'(m1), 32'd0);
        for (int i = 0; i < TMO - 1; i++) begin
            cyc(0, 0, 0, 0, 0, 0);  chk("s3_no_jam", 32'(jam), 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0);  chk("s3_jam", 32'(jam), 32'd1);
        chk("s3_m10_off", 32'(m10), 32'd0);
        cyc(1, 0, 0, 1, 0, 0);  chk("s3_jam_hold", 32'(jam), 32'd1);
        cyc(0, 0, 0, 0, 0, 1);  chk("s3_clr", 32'(jam), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);  chk("s3_next_m5", 32'(m5), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("s3_jam_push_m1", 32'(m1), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);

        // Tiny-stock instance: two 1-unit requests.
        b_c1 = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);  chk("s4_m1_on", 32'(bm1), 32'd1);
        b_c1 = 1'b0; b_sense = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);  b_sense = 1'b0;
        chk("s4_m1_off", 32'(bm1), 32'd0);
        chk("s4_empty", 32'(be1), 32'(INV));
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("s4_second_coin", 32'(bm1), 32'(!INV));
        chk("s4_drop", 32'(bdrop), 32'(INV));
        chk("s4_empty_hold", 32'(be1), 32'(INV));
        b_reload = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);  b_reload = 1'b0;
        chk("s4_reload", 32'(be1), 32'd0);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset("rst_rand");
            cyc($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
